// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - register access and interrupt handshake bundle between core and intr_ctrl
interface intr_ctrl_if;
    logic       reg_wr;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       ack;
    logic       iret;
    logic       interrupt;
    logic [2:0] active_id;

    modport master (
        output reg_wr, reg_addr, reg_wdata, ack, iret,
        input  reg_rdata, interrupt, active_id
    );

    modport slave (
        input  reg_wr, reg_addr, reg_wdata, ack, iret,
        output reg_rdata, interrupt, active_id
    );
endinterface

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller feeding the PC controller; INTR_LEVEL_EN adds level-sensitive sources
module intr_ctrl #(
    parameter int NUM_SOURCES = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pause,
    input  logic [NUM_SOURCES-1:0] irq_in,
    intr_ctrl_if.slave             bus
);
    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_SOURCES-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    logic                   gie_q, gie_d;
    logic                   spur_q, spur_d;
    logic                   intr_q, intr_d;
    logic [2:0]             id_q, id_d;
`ifdef INTR_LEVEL_EN
    logic [NUM_SOURCES-1:0] mode_q, mode_d;
`endif

    logic                   wr_en;
    logic [NUM_SOURCES-1:0] rise, lvl, req;
    logic [NUM_SOURCES-1:0] pick_oh, w1c, ack_clr, edge_next;
    logic [2:0]             pick_id;
    logic                   take, gie_set, gie_clr, spur_set, spur_clr;
    logic [7:0]             rdata;

    assign wr_en = bus.reg_wr && !pause;
    assign lvl   = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign req   = pending_q & mask_q;

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        pick_id = '0;
        pick_oh = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_id    = 3'(i);
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        intr_d   = intr_q;
        id_d     = id_q;
        take     = 1'b0;
        gie_set  = 1'b0;
        gie_clr  = 1'b0;
        spur_set = 1'b0;
        if (!pause) begin
            case (state_q)
                IDLE: begin
                    intr_d = 1'b0;
                    if (gie_q && |req) state_d = REQUEST;
                end
                REQUEST: begin
                    if (bus.ack && |req) begin
                        take    = 1'b1;
                        id_d    = pick_id;
                        gie_clr = 1'b1;
                        intr_d  = 1'b0;
                        state_d = SERVICE;
                    end else if (!gie_q || !(|req)) begin
                        intr_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        intr_d  = 1'b1;
                    end
                end
                SERVICE: begin
                    intr_d = 1'b0;
                    if (bus.iret) begin
                        gie_set = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (bus.ack && state_q != REQUEST) spur_set = 1'b1;
        end
    end

    always_comb begin
        mask_d   = mask_q;
        gie_d    = gie_q;
        w1c      = '0;
        spur_clr = 1'b0;
`ifdef INTR_LEVEL_EN
        mode_d   = mode_q;
`endif
        if (wr_en) begin
            case (bus.reg_addr)
                3'd0: mask_d = bus.reg_wdata[NUM_SOURCES-1:0];
                3'd1: w1c    = bus.reg_wdata[NUM_SOURCES-1:0];
                3'd2: begin
                    gie_d    = bus.reg_wdata[0];
                    spur_clr = bus.reg_wdata[2];
                end
`ifdef INTR_LEVEL_EN
                3'd4: mode_d = bus.reg_wdata[NUM_SOURCES-1:0];
`endif
                default: ;
            endcase
        end
        // Hardware events override a simultaneous software write to GIE.
        if (gie_clr) gie_d = 1'b0;
        if (gie_set) gie_d = 1'b1;
        spur_d    = spur_set | (spur_q & ~spur_clr);
        ack_clr   = take ? pick_oh : '0;
        edge_next = rise | (pending_q & ~(w1c | ack_clr));
`ifdef INTR_LEVEL_EN
        pending_d = (mode_q & lvl) | (~mode_q & edge_next);
`else
        pending_d = edge_next;
`endif
    end

    always_comb begin
        rdata = '0;
        case (bus.reg_addr)
            3'd0: rdata[NUM_SOURCES-1:0] = mask_q;
            3'd1: rdata[NUM_SOURCES-1:0] = pending_q;
            3'd2: rdata[2:0] = {spur_q, state_q == SERVICE, gie_q};
            3'd3: rdata[2:0] = id_q;
`ifdef INTR_LEVEL_EN
            3'd4: rdata[NUM_SOURCES-1:0] = mode_q;
`endif
            default: rdata = '0;
        endcase
    end

    assign bus.reg_rdata = rdata;
    assign bus.interrupt = intr_q;
    assign bus.active_id = id_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            state_q   <= IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            spur_q    <= 1'b0;
            intr_q    <= 1'b0;
            id_q      <= '0;
`ifdef INTR_LEVEL_EN
            mode_q    <= '0;
`endif
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            spur_q    <= spur_d;
            intr_q    <= intr_d;
            id_q      <= id_d;
`ifdef INTR_LEVEL_EN
            mode_q    <= mode_d;
`endif
        end
    end
endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller directly upstream of the program-counter controller.
- Synchronises up to 8 external request lines and latches them into pending bits; applies a per-source mask and a global enable (GIE).
- Drives the single `interrupt` request consumed by the PC controller and treats the controller's `save_accum` pulse as the vector-taken acknowledge.
- Re-arms on interrupt return. A small register file gives the core read/write access to control and status.

Parameters:
- NUM_SOURCES, 8, number of request lines (1..8).
- SYNC_STAGES, 2, synchroniser flops per request line (>=2).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- pause  input  1  pipeline stall; the FSM and register writes freeze while high.
- irq_in  input  NUM_SOURCES  asynchronous request lines.
- reg_wr  input  1  register write strobe.
- reg_addr  input  3  register select.
- reg_wdata  input  8  write data.
- reg_rdata  output  8  read data, combinational from reg_addr.
- ack  input  1  connected to the PC controller's save_accum; vector taken.
- iret  input  1  interrupt-return instruction retired (one-cycle pulse from decode).
- interrupt  output  1  request to the PC controller.
- active_id  output  3  index of the source being serviced.

Behaviour:
- Reset (asynchronous, reset_n low): all of the following clear to 0 and FSM = IDLE.
  - interrupt, active_id, pending, mask, GIE, spurious, synchroniser flops.
- Synchroniser: SYNC_STAGES flops per line. A rising edge of the last two synced samples sets pending[i] in the next cycle.
  - Capture continues during pause.
- Register map (NUM_SOURCES bits valid; upper bits read 0):
  - 0 MASK: R/W.
  - 1 PENDING: read; write-1-to-clear. If a set and a clear hit the same bit in one cycle, set wins.
  - 2 STATUS: bit0 GIE (R/W), bit1 IN_SERVICE (RO), bit2 SPURIOUS (sticky; write 1 to clear).
  - 3 ACTIVE: {5'b0, active_id}, RO.
  - 4 MODE: see Optional Feature.
  - 5-7: read 0, writes ignored.
  - reg_wr is ignored while pause=1.
- Request vector req = pending & MASK.
- FSM, advances only when pause=0:
  - IDLE: if GIE && |req -> REQUEST; interrupt goes to 1 on the following clock edge.
  - REQUEST: interrupt held at 1 until ack.
    - On ack: active_id <= lowest-index set bit of req; that pending bit clears; GIE <= 0; interrupt <= 0 in the same edge; -> SERVICE.
    - If software clears every req bit or GIE before ack: interrupt <= 0 -> IDLE.
  - SERVICE: IN_SERVICE=1; further requests stay pending, with no nesting.
    - On iret: GIE <= 1 -> IDLE.
    - A new request can reassert interrupt on the second cycle after iret at the earliest.
- Boundary conditions:
  - ack outside REQUEST: ignored; SPURIOUS <= 1.
  - iret outside SERVICE: ignored.
  - Software write to GIE in the same cycle as ack: ack's clear wins.
  - Software write to GIE in the same cycle as iret: iret's set wins.
- Reset mid-service returns to IDLE with GIE=0. Requests lost at reset are not recovered.
- Latency: irq_in edge to interrupt=1 is SYNC_STAGES+2 cycles, given GIE=1, source unmasked, FSM in IDLE, pause=0.

Optional Feature:
- Macro INTR_LEVEL_EN.
- Defined:
  - Register 4 MODE is R/W; MODE[i]=1 makes source i level-sensitive.
  - For level-sensitive sources, pending[i] mirrors the synced level; writes to clear it and clearing on ack have no effect.
  - The handler must quiesce the device before iret, otherwise the request re-fires immediately.
- Undefined:
  - All sources are edge-sensitive; MODE reads 0 and writes are ignored; no extra flops.

Test Plan:
- Edge request: reset, MASK=0x01, GIE=1, pulse irq_in[0] -> interrupt=1 exactly 4 cycles after the edge; ack -> interrupt=0, active_id=0, PENDING=0, STATUS=0x02.
- Priority: MASK=0x0C, raise irq_in[2] and irq_in[3] together -> on ack active_id=2, PENDING=0x08; iret -> interrupt reasserts 2 cycles later; next ack gives active_id=3.
- Masking and GIE: GIE=0, pulse irq_in[1] with MASK=0x02 -> interrupt stays 0, PENDING=0x02; write GIE=1 -> interrupt=1 within 2 cycles.
- Pause freeze: assert pause while in REQUEST, pulse ack -> state and pending unchanged; SPURIOUS stays 0; irq_in[4] edge during pause still sets PENDING bit 4.
- Spurious and withdraw: ack in IDLE -> STATUS bit2=1; in REQUEST write PENDING=0xFF -> interrupt=0 next cycle, FSM IDLE.
- Async reset in SERVICE: drop reset_n mid-cycle -> interrupt, active_id and registers read 0 immediately; INTR_LEVEL_EN build: MODE=0x01, hold irq_in[0] high -> interrupt reasserts after iret.
